// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: block width, FIFO entry layout and the
// register addresses the CW305 register block uses to reach the output FIFO.
package ascon_pkg;

   localparam int unsigned ASCON_BLOCK_W = 128;

   typedef struct packed {
      logic                     is_tag;
      logic [ASCON_BLOCK_W-1:0] data;
   } ascon_entry_t;

   localparam logic [7:0] REG_CRYPT_FIFO_CNT  = 8'h10;
   localparam logic [7:0] REG_CRYPT_FIFO_DATA = 8'h11;

endpackage

// File: rtl/ascon_fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one
// asynchronous read port, no reset so it can map onto distributed RAM.
module ascon_fifo_mem #(
   parameter int unsigned pDEPTH = 8,
   parameter int unsigned pWIDTH = 129,
   localparam int unsigned AW    = $clog2(pDEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [pWIDTH-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [pWIDTH-1:0] rdata_c
);

   logic [pWIDTH-1:0] mem_q [pDEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/ascon_out_fifo.sv
// Output FIFO for Ascon ciphertext blocks and the final tag, with a one-entry
// skid register so a same-cycle ciphertext+tag pair is never lost.
module ascon_out_fifo
   import ascon_pkg::*;
#(
   parameter int unsigned pDEPTH      = 8,
   parameter int unsigned pDATA_WIDTH = ASCON_BLOCK_W,
   parameter int unsigned pCNT_WIDTH  = $clog2(pDEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   ct_valid,
   input  logic [pDATA_WIDTH-1:0] ct_data,
   input  logic                   tag_valid,
   input  logic [pDATA_WIDTH-1:0] tag_data,
   output logic                   in_ready,
   input  logic                   rd_pop,
   output logic [pDATA_WIDTH-1:0] rd_data,
   output logic                   rd_is_tag,
   output logic [pCNT_WIDTH-1:0]  count,
   output logic                   empty,
   output logic                   full,
   output logic                   done,
   output logic                   overflow
);

   localparam int unsigned PTR_W   = $clog2(pDEPTH);
   localparam int unsigned ENTRY_W = pDATA_WIDTH + 1;

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [pCNT_WIDTH-1:0]  count_q, count_d;
   logic                   empty_q, empty_d, full_q, full_d, rdy_q, rdy_d;
   logic                   done_q, done_d, ovf_q, ovf_d, pend_q, pend_d;
   logic [pDATA_WIDTH-1:0] hold_q, hold_d;
   logic                   wr_en, pop_en, mem_we;
   logic [ENTRY_W-1:0]     wr_entry, rd_entry;

   ascon_fifo_mem #(
      .pDEPTH (pDEPTH),
      .pWIDTH (ENTRY_W)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_c (rd_entry)
   );

   // Write arbitration: pending tag first, then ciphertext, then tag.
   always_comb begin
      wr_en    = 1'b0;
      wr_entry = '0;
      pop_en   = rd_pop && !empty_q;
      pend_d   = pend_q;
      hold_d   = hold_q;
      done_d   = done_q;
      ovf_d    = ovf_q;

      if (pend_q) begin
         if (!full_q) begin
            wr_en    = 1'b1;
            wr_entry = {1'b1, hold_q};
            pend_d   = 1'b0;
         end
      end else if (!full_q) begin
         if (ct_valid) begin
            wr_en    = 1'b1;
            wr_entry = {1'b0, ct_data};
            if (tag_valid) begin
               pend_d = 1'b1;
               hold_d = tag_data;
            end
         end else if (tag_valid) begin
            wr_en    = 1'b1;
            wr_entry = {1'b1, tag_data};
         end
      end

      if ((ct_valid || tag_valid) && !rdy_q) begin
         ovf_d = 1'b1;
      end
      if (wr_en && wr_entry[pDATA_WIDTH]) begin
         done_d = 1'b1;
      end

      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
      count_d  = count_q + pCNT_WIDTH'(wr_en) - pCNT_WIDTH'(pop_en);

      // Flush wins over anything else happening this cycle.
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         pend_d   = 1'b0;
         done_d   = 1'b0;
         ovf_d    = 1'b0;
      end

      mem_we  = wr_en && !clear;
      empty_d = (count_d == '0);
      full_d  = (count_d == pCNT_WIDTH'(pDEPTH));
      rdy_d   = !full_d && !pend_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         rdy_q    <= 1'b1;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         pend_q   <= 1'b0;
         hold_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         rdy_q    <= rdy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         pend_q   <= pend_d;
         hold_q   <= hold_d;
      end
   end

   assign in_ready  = rdy_q;
   assign count     = count_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign rd_data   = empty_q ? '0 : rd_entry[pDATA_WIDTH-1:0];
   assign rd_is_tag = !empty_q && rd_entry[pDATA_WIDTH];

endmodule

// File: tb/tb_ascon_out_fifo.sv
// Directed + random bench for ascon_out_fifo against a queue-based model
// of the ciphertext/tag output buffer.
module tb_ascon_out_fifo;

   localparam int unsigned D  = 8;
   localparam int unsigned W  = 128;
   localparam int unsigned CW = 4;
   localparam int unsigned EW = W + 1;

   logic          clk = 1'b0;
   logic          reset, clear, ct_valid, tag_valid, rd_pop;
   logic [W-1:0]  ct_data, tag_data, rd_data;
   logic          in_ready, rd_is_tag, empty, full, done, overflow;
   logic [CW-1:0] count;

   int errors = 0;
   int checks = 0;

   // Reference model: queue of {is_tag, data}, plus skid and sticky flags.
   logic [W:0]   mq[$];
   bit           m_pend, m_done, m_ovf;
   logic [W-1:0] m_hold;

   always #5 clk = ~clk;

   ascon_out_fifo #(
      .pDEPTH      (D),
      .pDATA_WIDTH (W),
      .pCNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .ct_valid  (ct_valid),
      .ct_data   (ct_data),
      .tag_valid (tag_valid),
      .tag_data  (tag_data),
      .in_ready  (in_ready),
      .rd_pop    (rd_pop),
      .rd_data   (rd_data),
      .rd_is_tag (rd_is_tag),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .done      (done),
      .overflow  (overflow)
   );

   function automatic logic [W-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [W-1:0] rep(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pend = 1'b0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_step(input bit cv, input logic [W-1:0] cd, input bit tv,
                             input logic [W-1:0] td, input bit pop, input bit clr);
      bit         is_full, rdy, we;
      logic [W:0] w;
      if (clr) begin
         model_reset();
         return;
      end
      is_full = (mq.size() == D);
      rdy     = !is_full && !m_pend;
      we      = 1'b0;
      w       = '0;
      if (m_pend && !is_full) begin
         we = 1'b1; w = {1'b1, m_hold}; m_pend = 1'b0;
      end else if (rdy && cv) begin
         we = 1'b1; w = {1'b0, cd};
         if (tv) begin m_pend = 1'b1; m_hold = td; end
      end else if (rdy && tv) begin
         we = 1'b1; w = {1'b1, td};
      end
      if ((cv || tv) && !rdy) m_ovf = 1'b1;
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (we) begin
         mq.push_back(w);
         if (w[W]) m_done = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [W-1:0] hd;
      logic         ht;
      hd = (mq.size() > 0) ? mq[0][W-1:0] : '0;
      ht = (mq.size() > 0) ? mq[0][W] : 1'b0;
      chk({tag, ".count"},    EW'(count),     EW'(mq.size()));
      chk({tag, ".empty"},    EW'(empty),     EW'(mq.size() == 0));
      chk({tag, ".full"},     EW'(full),      EW'(mq.size() == D));
      chk({tag, ".in_ready"}, EW'(in_ready),  EW'((mq.size() != D) && !m_pend));
      chk({tag, ".done"},     EW'(done),      EW'(m_done));
      chk({tag, ".overflow"}, EW'(overflow),  EW'(m_ovf));
      chk({tag, ".rd_data"},  EW'(rd_data),   EW'(hd));
      chk({tag, ".rd_is_tag"},EW'(rd_is_tag), EW'(ht));
   endtask

   // One clock cycle: drive inputs, advance model and DUT, then compare.
   task automatic step(input bit cv, input logic [W-1:0] cd, input bit tv,
                       input logic [W-1:0] td, input bit pop, input bit clr,
                       input string tag);
      ct_valid = cv; ct_data = cd; tag_valid = tv; tag_data = td;
      rd_pop = pop; clear = clr;
      model_step(cv, cd, tv, td, pop, clr);
      @(posedge clk);
      #1;
      ct_valid = 1'b0; tag_valid = 1'b0; rd_pop = 1'b0; clear = 1'b0;
      check_all(tag);
   endtask

   task automatic push_ct(input logic [W-1:0] d, input string tag);
      step(1'b1, d, 1'b0, '0, 1'b0, 1'b0, tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, tag);
   endtask

   task automatic pop1(input string tag);
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, tag);
   endtask

   task automatic flush(input string tag);
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, tag);
   endtask

   initial begin
      logic [W-1:0] first;
      logic [W-1:0] exp_d [4];
      bit           exp_t [4];

      reset = 1'b1; clear = 1'b0; ct_valid = 1'b0; tag_valid = 1'b0; rd_pop = 1'b0;
      ct_data = '0; tag_data = '0;
      m_hold = '0;
      model_reset();
      #3;
      check_all("rst");
      chk("rst.in_ready", EW'(in_ready), EW'(1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all("rst.rel");

      // 1: three ciphertext blocks then a tag, drained in order.
      push_ct(rep(8'h11), "t1.w0");
      push_ct(rep(8'h22), "t1.w1");
      push_ct(rep(8'h33), "t1.w2");
      step(1'b0, '0, 1'b1, rep(8'hAA), 1'b0, 1'b0, "t1.tag");
      chk("t1.count4", EW'(count), EW'(4));
      chk("t1.done", EW'(done), EW'(1));
      exp_d = '{rep(8'h11), rep(8'h22), rep(8'h33), rep(8'hAA)};
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1.head%0d", i), {rd_is_tag, rd_data}, {exp_t[i], exp_d[i]});
         pop1($sformatf("t1.pop%0d", i));
      end

      // 2: same-cycle ciphertext and tag go through the skid register.
      flush("t2.clr");
      step(1'b1, rep(8'h55), 1'b1, rep(8'h66), 1'b0, 1'b0, "t2.pair");
      chk("t2.stall", EW'(in_ready), EW'(0));
      idle("t2.idle");
      chk("t2.ready", EW'(in_ready), EW'(1));
      chk("t2.count", EW'(count), EW'(2));
      chk("t2.ovf", EW'(overflow), EW'(0));
      chk("t2.head0", {rd_is_tag, rd_data}, {1'b0, rep(8'h55)});
      pop1("t2.pop0");
      chk("t2.head1", {rd_is_tag, rd_data}, {1'b1, rep(8'h66)});
      pop1("t2.pop1");

      // 3: fill to capacity, ninth write dropped.
      flush("t3.clr");
      first = rnd();
      push_ct(first, "t3.w0");
      for (int i = 1; i < D; i++) push_ct(rnd(), "t3.fill");
      push_ct(rnd(), "t3.w8");
      chk("t3.full", EW'(full), EW'(1));
      chk("t3.ovf", EW'(overflow), EW'(1));
      chk("t3.count", EW'(count), EW'(D));
      chk("t3.head", EW'(rd_data), EW'(first));

      // 4: steady push+pop at count=4, pointers wrap.
      flush("t4.clr");
      for (int i = 0; i < 4; i++) push_ct(rnd(), "t4.pre");
      for (int i = 0; i < 20; i++) begin
         step(1'b1, rnd(), 1'b0, '0, 1'b1, 1'b0, "t4.pp");
         chk("t4.count4", EW'(count), EW'(4));
      end

      // 5: pop while empty is harmless.
      flush("t5.clr");
      pop1("t5.pop");
      chk("t5.count", EW'(count), EW'(0));
      chk("t5.data", EW'(rd_data), EW'(0));
      chk("t5.ovf", EW'(overflow), EW'(0));

      // 6: async reset mid-stream with a pending tag, then clear after refill.
      flush("t6.clr0");
      for (int i = 0; i < 4; i++) push_ct(rnd(), "t6.pre");
      step(1'b1, rnd(), 1'b1, rnd(), 1'b0, 1'b0, "t6.pair");
      chk("t6.count5", EW'(count), EW'(5));
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("t6.rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all("t6.rel");
      for (int i = 0; i < 3; i++) push_ct(rnd(), "t6.refill");
      step(1'b0, '0, 1'b1, rnd(), 1'b0, 1'b0, "t6.tag");
      flush("t6.clr1");
      chk("t6.clr_count", EW'(count), EW'(0));
      chk("t6.clr_done", EW'(done), EW'(0));

      // Random traffic including pairs, overflow, pops and occasional flushes.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 2) != 0, rnd(), $urandom_range(0, 5) == 0, rnd(),
              $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ascon_out_fifo.md
# ascon_out_fifo

Output buffer between the Ascon-128 core and the CW305 register interface. It captures every ciphertext block and the final tag the core emits, in emission order, into a small FIFO. The register block exposes that FIFO as `REG_CRYPT_FIFO_CNT` and `REG_CRYPT_FIFO_DATA`, and drains it after the host sees `done` in `REG_CRYPT_STATUS`. Entries carry a tag marker, so the host can separate the ciphertext from the tag without knowing the message length.

## Interface
Parameters:
- `pDEPTH`, 8: number of entries; must be a power of 2, at least 2.
- `pDATA_WIDTH`, 128: width of one block.
- `pCNT_WIDTH`, `$clog2(pDEPTH)+1`: width of the occupancy count.

Ports:
- `clk`  in  1  crypto clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush; one-cycle pulse from the register block when `REG_CRYPT_GO` is written.
- `ct_valid`  in  1  core presents a ciphertext block.
- `ct_data`  in  pDATA_WIDTH  ciphertext block.
- `tag_valid`  in  1  core presents the final tag.
- `tag_data`  in  pDATA_WIDTH  tag.
- `in_ready`  out  1  block can accept a write this cycle; drives core stall.
- `rd_pop`  in  1  one-cycle pulse; discards the head entry.
- `rd_data`  out  pDATA_WIDTH  head entry, valid while `!empty`.
- `rd_is_tag`  out  1  head entry is the tag.
- `count`  out  pCNT_WIDTH  occupancy, 0..pDEPTH.
- `empty`  out  1  FIFO is empty.
- `full`  out  1  FIFO is full.
- `done`  out  1  tag has been stored; sticky until `clear` or `reset`.
- `overflow`  out  1  sticky error: a write was dropped.

## Operation
Storage:
- Circular array of `{is_tag, data}`.
- Write pointer and read pointer are each `$clog2(pDEPTH)` bits and wrap modulo `pDEPTH`.
- `count` is a separate register, not derived from the pointers.

Write sources, in priority order:
- A pending tag held in the skid register.
- `ct_valid`.
- `tag_valid`.

Skid register:
- One entry, `tag_hold` plus a pending bit.
- When `ct_valid` and `tag_valid` arrive in the same cycle, the ciphertext is written and the tag is latched into the skid register.
- The pending tag is written on the next cycle in which `!full`.

`in_ready = !full && !tag_pending`.

A write that arrives while `!in_ready`:
- The data is dropped and `overflow` is set.
- Also applies when the skid register is already occupied and a new tag arrives; that tag is dropped and `overflow` is set.
- FIFO contents and pointers are unchanged.

Pop:
- `rd_pop` while `empty` is ignored; no error is flagged.

Push and pop in the same cycle:
- If `!empty`, both take effect and `count` is unchanged.
- If `empty`, the push takes effect and the pop is ignored.
- If `full`, the pop frees a slot but `in_ready` was already low, so the incoming write is still dropped.

`done`:
- Set in the cycle a tag entry is written into the array.

`clear`:
- Resets pointers, `count`, `done`, `overflow` and the pending bit in the next cycle.
- Takes priority over any same-cycle push or pop.
- Array contents are not cleared.

Reset:
- Asynchronous, same effect as `clear`.
- Values while `reset` is high: `count=0`, `empty=1`, `full=0`, `in_ready=1`, `done=0`, `overflow=0`, `rd_is_tag=0`, `rd_data=0`.
- `rd_data` is masked to 0 while `empty`.

## Timing
- Write latency: data accepted at edge N is visible on `rd_data` and counted in `count` after edge N, i.e. readable in cycle N+1.
- First-word fall-through: the head is presented combinationally from the array at the read pointer.
- Pop: the next entry appears the cycle after the `rd_pop` edge.
- Status outputs `empty`, `full` and `in_ready` are registered and consistent with `count` in every cycle.
- Maximum throughput is one write and one pop per cycle.
- A same-cycle ciphertext-plus-tag pair takes 2 cycles to enter the FIFO; `in_ready` is low for exactly 1 cycle.

## Structure
Shared package `ascon_pkg` holds:
- The entry typedef `{logic is_tag; logic [127:0] data;}`.
- `ASCON_BLOCK_W = 128`.
- The `REG_CRYPT_FIFO_*` address constants shared with the register block.

Sub-module `ascon_fifo_mem`:
- Simple dual-port array: one write port, one asynchronous read port.
- Allows mapping to LUTRAM on Artix-7.

Pointer logic, skid register and flags stay in `ascon_out_fifo`.

## Test plan
1. Reset, then 3 ciphertext writes `0x11..`, `0x22..`, `0x33..`, then a tag `0xAA..` → `count=4`; pops return the blocks in order with `rd_is_tag=0,0,0,1`; `done` goes to 1 on the tag write.
2. Same-cycle ciphertext `0x55..` and tag `0x66..` → `in_ready` low for 1 cycle; the entries are stored ciphertext first, then tag; `overflow=0`.
3. Fill to 8 entries, then write a 9th → `full=1`, `overflow=1`, `count=8`, and the head is still entry 0.
4. At `count=4`, push and pop in the same cycle for 20 cycles → `count` stays 4, the pointers wrap, and the data comes out in order.
5. `rd_pop` while empty → `count=0`, `overflow=0`, `rd_data=0`.
6. Assert `reset` mid-stream at `count=5` with the skid register pending, then `clear` after refilling → all outputs return to their reset values immediately on `reset`, and again one cycle after `clear`.
